// File: rtl/kronos_wb_bridge.sv
// Kronos core memory port to Wishbone classic master bridge (IDLE -> BUS -> RESP).
// Define WB_TIMEOUT_EN to compile in the bus-wait timeout counter and the bus_err flag.
module kronos_wb_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = 32'hFFFF_FFFF
) (
  input  logic        clk_core,
  input  logic        rst_core,
  input  logic        core_req,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wr_data,
  input  logic [3:0]  core_mask,
  input  logic        core_wr_en,
  output logic        core_ack,
  output logic [31:0] core_rd_data,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic [31:0] wb_addr,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic        bus_timeout;
  logic        cyc_nxt;
  logic        stb_nxt;
  logic        we_nxt;
  logic [3:0]  sel_nxt;
  logic [31:0] addr_nxt;
  logic [31:0] dat_o_nxt;
  logic        ack_nxt;
  logic [31:0] rd_data_nxt;
  logic        err_nxt;

`ifdef WB_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] wait_cnt;

  // Held at zero outside BUS, so it is already clear on the first BUS cycle.
  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      wait_cnt <= '0;
    end else if (state != BUS) begin
      wait_cnt <= '0;
    end else if (!wb_ack) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign bus_timeout = (state == BUS) && !wb_ack && (wait_cnt == TERMINAL);
`else
  // Without the timeout the bus waits forever; the parameter is inert.
  assign bus_timeout = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (core_req) state_nxt = BUS;
      BUS:     if (wb_ack || bus_timeout) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cyc_nxt     = wb_cyc;
    stb_nxt     = wb_stb;
    we_nxt      = wb_we;
    sel_nxt     = wb_sel;
    addr_nxt    = wb_addr;
    dat_o_nxt   = wb_dat_o;
    rd_data_nxt = core_rd_data;
    ack_nxt     = 1'b0;
    err_nxt     = 1'b0;
    unique case (state)
      IDLE: begin
        if (core_req) begin
          cyc_nxt   = 1'b1;
          stb_nxt   = 1'b1;
          we_nxt    = core_wr_en;
          sel_nxt   = core_wr_en ? core_mask : '1;
          addr_nxt  = core_addr;
          dat_o_nxt = core_wr_en ? core_wr_data : '0;
        end
      end
      BUS: begin
        // A real ack on the terminal count takes priority over the timeout.
        if (wb_ack || bus_timeout) begin
          cyc_nxt     = 1'b0;
          stb_nxt     = 1'b0;
          ack_nxt     = 1'b1;
          err_nxt     = bus_timeout;
          rd_data_nxt = bus_timeout ? ERR_DATA : wb_dat_i;
        end
      end
      RESP:    ;
      default: ;
    endcase
  end

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      wb_cyc       <= 1'b0;
      wb_stb       <= 1'b0;
      wb_we        <= 1'b0;
      wb_sel       <= '0;
      wb_addr      <= '0;
      wb_dat_o     <= '0;
      core_ack     <= 1'b0;
      core_rd_data <= '0;
      bus_err      <= 1'b0;
    end else begin
      wb_cyc       <= cyc_nxt;
      wb_stb       <= stb_nxt;
      wb_we        <= we_nxt;
      wb_sel       <= sel_nxt;
      wb_addr      <= addr_nxt;
      wb_dat_o     <= dat_o_nxt;
      core_ack     <= ack_nxt;
      core_rd_data <= rd_data_nxt;
      bus_err      <= err_nxt;
    end
  end

endmodule

// File: tb/tb_kronos_wb_bridge.sv
// Self-checking bench for kronos_wb_bridge; transaction-level reference model.
// Build with WB_TIMEOUT_EN defined to exercise the timeout path (TIMEOUT_CYCLES=8).
module tb_kronos_wb_bridge;

`ifdef WB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif
  localparam logic [31:0] ERR = 32'hFFFF_FFFF;

  logic        clk_core = 1'b0;
  logic        rst_core = 1'b0;
  logic        core_req = 1'b0;
  logic [31:0] core_addr = '0;
  logic [31:0] core_wr_data = '0;
  logic [3:0]  core_mask = '0;
  logic        core_wr_en = 1'b0;
  logic        core_ack;
  logic [31:0] core_rd_data;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_addr, wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack = 1'b0;
  logic        bus_err;

  int errors = 0;
  int checks = 0;

  kronos_wb_bridge #(
    .TIMEOUT_CYCLES(TO),
    .ERR_DATA(ERR)
  ) dut (
    .clk_core(clk_core), .rst_core(rst_core),
    .core_req(core_req), .core_addr(core_addr), .core_wr_data(core_wr_data),
    .core_mask(core_mask), .core_wr_en(core_wr_en),
    .core_ack(core_ack), .core_rd_data(core_rd_data),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
    .wb_addr(wb_addr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack),
    .bus_err(bus_err)
  );

  always #5 clk_core = ~clk_core;

  // Observations of one transaction (cycle 0 = the cycle the request is presented).
  int          obs_first, obs_cnt, obs_ack;
  logic        obs_we, obs_stable, obs_err, obs_pre_ack;
  logic [3:0]  obs_sel;
  logic [31:0] obs_addr, obs_dat, obs_rd;

  // Reference expectations and the values the bridge should be holding afterwards.
  int          e_len, e_ack;
  logic        e_err;
  logic [3:0]  e_sel;
  logic [31:0] e_dat, e_rd;
  logic [31:0] m_addr = '0, m_dat = '0, m_rd = '0;
  logic [3:0]  m_sel = '0;
  logic        m_we = 1'b0;

  task automatic model(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m,
                       input logic we, input int delay, input logic [31:0] rd);
    bool_t_dummy();
`ifdef WB_TIMEOUT_EN
    e_err = !(delay >= 1 && delay <= TO);
    e_len = e_err ? TO : delay;
`else
    e_err = 1'b0;
    e_len = delay;
`endif
    e_ack  = e_len + 1;
    e_sel  = we ? m : 4'hF;
    e_dat  = we ? wd : 32'h0;
    e_rd   = e_err ? ERR : rd;
    m_addr = a;
    m_dat  = e_dat;
    m_sel  = e_sel;
    m_we   = we;
    m_rd   = e_rd;
  endtask

  task automatic bool_t_dummy();
  endtask

  // Core + slave driver. delay = BUS cycle (1-based) on which the slave acks, 0 = never.
  task automatic drive_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m,
                           input logic we, input int delay, input logic [31:0] rd,
                           input bit keep, input int max_c);
    obs_first = -1; obs_cnt = 0; obs_ack = -1; obs_stable = 1'b1;
    obs_err = 1'b0; obs_pre_ack = 1'b0; obs_rd = '0;
    obs_we = 1'b0; obs_sel = '0; obs_addr = '0; obs_dat = '0;
    @(posedge clk_core); #1;
    rst_core = 1'b0;
    core_req = 1'b1; core_addr = a; core_wr_data = wd; core_mask = m; core_wr_en = we;
    for (int c = 0; c <= max_c; c++) begin
      if (c > 0) begin @(posedge clk_core); #1; end
      wb_ack   = (delay > 0) && (c == delay);
      wb_dat_i = wb_ack ? rd : $urandom;
      @(negedge clk_core);
      if (c == 0) obs_pre_ack = core_ack;
      if (wb_stb === 1'b1) begin
        if (obs_first < 0) begin
          obs_first = c; obs_we = wb_we; obs_sel = wb_sel; obs_addr = wb_addr; obs_dat = wb_dat_o;
        end else if (wb_we !== obs_we || wb_sel !== obs_sel || wb_addr !== obs_addr ||
                     wb_dat_o !== obs_dat) begin
          obs_stable = 1'b0;
        end
        if (wb_cyc !== 1'b1) obs_stable = 1'b0;
        obs_cnt++;
      end
      if (core_ack === 1'b1) begin
        obs_ack = c; obs_rd = core_rd_data; obs_err = bus_err;
        break;
      end
    end
    wb_ack = 1'b0;
    if (!keep) core_req = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_core = 1'b1;
    #1;
    checks++; if ({wb_cyc, wb_stb, wb_we, core_ack, bus_err} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=00000", {wb_cyc, wb_stb, wb_we, core_ack, bus_err}); end
    checks++; if ({wb_sel, wb_addr, wb_dat_o, core_rd_data} !== '0) begin
      errors++; $display("FAIL reset_data sel=%h addr=%h dat=%h rd=%h exp=0", wb_sel, wb_addr, wb_dat_o, core_rd_data); end
    core_req = 1'b1;
    repeat (2) @(posedge clk_core);
    #1;
    checks++; if (wb_stb !== 1'b0) begin
      errors++; $display("FAIL reset_hold_stb got=%b exp=0", wb_stb); end
    // Reset is released in the same cycle the read is presented.
    model(32'h40, 32'h0, 4'h0, 1'b0, 1, 32'hA5A5_0040);
    drive_txn(32'h40, 32'h0, 4'h0, 1'b0, 1, 32'hA5A5_0040, 0, 20);
    checks++; if (obs_first !== 1) begin
      errors++; $display("FAIL first_accept stb_cycle got=%0d exp=1", obs_first); end
    checks++; if (obs_ack !== e_ack || obs_rd !== e_rd) begin
      errors++; $display("FAIL first_accept ack=%0d rd=%h exp ack=%0d rd=%h", obs_ack, obs_rd, e_ack, e_rd); end
  endtask

  task automatic test_read();
    model(32'h0000_0010, 32'h0, 4'h0, 1'b0, 2, 32'hCAFE_0001);
    drive_txn(32'h0000_0010, 32'h0, 4'h0, 1'b0, 2, 32'hCAFE_0001, 0, 20);
    checks++; if (obs_first !== 1 || obs_cnt !== e_len) begin
      errors++; $display("FAIL read_stb first=%0d cnt=%0d exp first=1 cnt=%0d", obs_first, obs_cnt, e_len); end
    checks++; if (obs_we !== 1'b0 || obs_sel !== e_sel || obs_addr !== 32'h10 || obs_dat !== e_dat) begin
      errors++; $display("FAIL read_fields we=%b sel=%h addr=%h dat=%h exp we=0 sel=%h addr=10 dat=%h",
                         obs_we, obs_sel, obs_addr, obs_dat, e_sel, e_dat); end
    checks++; if (obs_ack !== e_ack || obs_rd !== 32'hCAFE_0001 || obs_err !== 1'b0) begin
      errors++; $display("FAIL read_resp ack=%0d rd=%h err=%b exp ack=%0d rd=cafe0001 err=0", obs_ack, obs_rd, obs_err, e_ack); end
  endtask

  task automatic test_write();
    model(32'h0000_0104, 32'h1234_5678, 4'b0011, 1'b1, 1, 32'h0BAD_F00D);
    drive_txn(32'h0000_0104, 32'h1234_5678, 4'b0011, 1'b1, 1, 32'h0BAD_F00D, 1, 20);
    checks++; if (obs_we !== 1'b1 || obs_sel !== 4'b0011 || obs_dat !== 32'h1234_5678 || obs_addr !== 32'h104) begin
      errors++; $display("FAIL write_fields we=%b sel=%h dat=%h addr=%h exp we=1 sel=3 dat=12345678 addr=104",
                         obs_we, obs_sel, obs_dat, obs_addr); end
    checks++; if (obs_ack !== 2 || obs_rd !== e_rd) begin
      errors++; $display("FAIL write_ack cycle=%0d rd=%h exp cycle=2 rd=%h", obs_ack, obs_rd, e_rd); end
    model(32'h0000_0108, 32'h0, 4'h0, 1'b0, 1, 32'h0000_0108);
    drive_txn(32'h0000_0108, 32'h0, 4'h0, 1'b0, 1, 32'h0000_0108, 0, 20);
    checks++; if (obs_first !== 1 || obs_rd !== e_rd) begin
      errors++; $display("FAIL write_next_accept stb_cycle=%0d rd=%h exp stb_cycle=1 rd=%h", obs_first, obs_rd, e_rd); end
  endtask

  task automatic test_back_to_back();
    int stray;
    model(32'h300, 32'h0, 4'h0, 1'b0, 1, 32'h1111_1111);
    drive_txn(32'h300, 32'h0, 4'h0, 1'b0, 1, 32'h1111_1111, 1, 20);
    checks++; if (obs_cnt !== 1 || obs_ack !== e_ack || obs_rd !== e_rd) begin
      errors++; $display("FAIL b2b_first cnt=%0d ack=%0d rd=%h exp cnt=1 ack=%0d rd=%h", obs_cnt, obs_ack, obs_rd, e_ack, e_rd); end
    model(32'h304, 32'h0, 4'h0, 1'b0, 3, 32'h2222_2222);
    drive_txn(32'h304, 32'h0, 4'h0, 1'b0, 3, 32'h2222_2222, 0, 20);
    checks++; if (obs_first !== 1 || obs_pre_ack !== 1'b0) begin
      errors++; $display("FAIL b2b_idle_gap stb_cycle=%0d prev_ack=%b exp stb_cycle=1 prev_ack=0", obs_first, obs_pre_ack); end
    checks++; if (obs_cnt !== 3 || obs_ack !== e_ack || obs_rd !== e_rd) begin
      errors++; $display("FAIL b2b_second cnt=%0d ack=%0d rd=%h exp cnt=3 ack=%0d rd=%h", obs_cnt, obs_ack, obs_rd, e_ack, e_rd); end
    stray = 0;
    repeat (4) begin
      @(negedge clk_core);
      if (wb_stb !== 1'b0 || core_ack !== 1'b0) stray++;
    end
    checks++; if (stray !== 0) begin
      errors++; $display("FAIL b2b_extra_pulse got=%0d exp=0", stray); end
  endtask

  task automatic test_spurious_ack();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_core); #1;
      wb_ack = 1'b1; wb_dat_i = $urandom;
      @(negedge clk_core);
      checks++; if (core_ack !== 1'b0 || wb_cyc !== 1'b0 || wb_stb !== 1'b0 || core_rd_data !== m_rd) begin
        errors++; $display("FAIL spurious_ack%0d ack=%b cyc=%b stb=%b rd=%h exp 0 0 0 rd=%h",
                           i, core_ack, wb_cyc, wb_stb, core_rd_data, m_rd); end
      checks++; if (wb_addr !== m_addr || wb_sel !== m_sel || wb_we !== m_we || wb_dat_o !== m_dat) begin
        errors++; $display("FAIL spurious_hold%0d addr=%h sel=%h we=%b dat=%h exp %h %h %b %h",
                           i, wb_addr, wb_sel, wb_we, wb_dat_o, m_addr, m_sel, m_we, m_dat); end
    end
    wb_ack = 1'b0;
  endtask

  task automatic test_reset_mid_bus();
    int seen;
    @(posedge clk_core); #1;
    core_req = 1'b1; core_addr = 32'h200; core_wr_en = 1'b1; core_wr_data = 32'hDEAD_BEEF; core_mask = 4'hC;
    wb_ack = 1'b0;
    repeat (3) @(posedge clk_core);
    #2;
    checks++; if (wb_stb !== 1'b1 || wb_cyc !== 1'b1) begin
      errors++; $display("FAIL midbus_pre cyc=%b stb=%b exp 1 1", wb_cyc, wb_stb); end
    rst_core = 1'b1;
    #1;
    checks++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || core_ack !== 1'b0 || wb_addr !== 32'h0) begin
      errors++; $display("FAIL midbus_reset cyc=%b stb=%b ack=%b addr=%h exp 0 0 0 0", wb_cyc, wb_stb, core_ack, wb_addr); end
    core_req = 1'b0; wb_ack = 1'b1;
    @(posedge clk_core); #1;
    rst_core = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk_core);
      if (core_ack !== 1'b0 || wb_stb !== 1'b0) seen++;
    end
    wb_ack = 1'b0;
    checks++; if (seen !== 0) begin
      errors++; $display("FAIL midbus_no_ack got=%0d exp=0", seen); end
    model(32'h204, 32'h0, 4'h0, 1'b0, 2, 32'h5555_AAAA);
    drive_txn(32'h204, 32'h0, 4'h0, 1'b0, 2, 32'h5555_AAAA, 0, 20);
    checks++; if (obs_first !== 1 || obs_ack !== e_ack || obs_rd !== e_rd || obs_sel !== e_sel) begin
      errors++; $display("FAIL midbus_recover first=%0d ack=%0d rd=%h sel=%h exp 1 %0d %h %h",
                         obs_first, obs_ack, obs_rd, obs_sel, e_ack, e_rd, e_sel); end
  endtask

  task automatic test_random();
    logic [31:0] a, wd, rd;
    logic [3:0]  m;
    logic        we;
    int          d;
    bit          keep;
    for (int i = 0; i < 24; i++) begin
      a = $urandom; wd = $urandom; rd = $urandom; m = 4'($urandom);
      we = 1'($urandom); d = $urandom_range(5, 1); keep = 1'($urandom);
      model(a, wd, m, we, d, rd);
      drive_txn(a, wd, m, we, d, rd, keep, 20);
      checks++; if (obs_first !== 1 || obs_cnt !== e_len || obs_stable !== 1'b1) begin
        errors++; $display("FAIL rnd%0d_stb first=%0d cnt=%0d stable=%b exp 1 %0d 1", i, obs_first, obs_cnt, obs_stable, e_len); end
      checks++; if (obs_addr !== a || obs_we !== we || obs_sel !== e_sel || obs_dat !== e_dat) begin
        errors++; $display("FAIL rnd%0d_fields addr=%h we=%b sel=%h dat=%h exp %h %b %h %h",
                           i, obs_addr, obs_we, obs_sel, obs_dat, a, we, e_sel, e_dat); end
      checks++; if (obs_ack !== e_ack || obs_rd !== e_rd || obs_err !== e_err) begin
        errors++; $display("FAIL rnd%0d_resp ack=%0d rd=%h err=%b exp %0d %h %b", i, obs_ack, obs_rd, obs_err, e_ack, e_rd, e_err); end
    end
  endtask

`ifdef WB_TIMEOUT_EN
  task automatic test_timeout();
    model(32'h400, 32'h0, 4'h0, 1'b0, 0, 32'h0);
    drive_txn(32'h400, 32'h0, 4'h0, 1'b0, 0, 32'h0, 0, TO + 6);
    checks++; if (obs_cnt !== TO || obs_ack !== TO + 1) begin
      errors++; $display("FAIL timeout_len stb_cycles=%0d ack=%0d exp %0d %0d", obs_cnt, obs_ack, TO, TO + 1); end
    checks++; if (obs_err !== 1'b1 || obs_rd !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL timeout_resp err=%b rd=%h exp 1 ffffffff", obs_err, obs_rd); end
    @(negedge clk_core);
    checks++; if (bus_err !== 1'b0 || core_ack !== 1'b0) begin
      errors++; $display("FAIL timeout_one_cycle err=%b ack=%b exp 0 0", bus_err, core_ack); end
    model(32'h404, 32'h0, 4'h0, 1'b0, TO, 32'h7777_0404);
    drive_txn(32'h404, 32'h0, 4'h0, 1'b0, TO, 32'h7777_0404, 0, TO + 6);
    checks++; if (obs_ack !== e_ack || obs_err !== 1'b0 || obs_rd !== e_rd) begin
      errors++; $display("FAIL timeout_ack_wins ack=%0d err=%b rd=%h exp %0d 0 %h", obs_ack, obs_err, obs_rd, e_ack, e_rd); end
  endtask
`else
  task automatic test_no_timeout();
    drive_txn(32'h400, 32'h0, 4'h0, 1'b0, 0, 32'h0, 1, 40);
    checks++; if (obs_ack !== -1 || obs_cnt !== 40) begin
      errors++; $display("FAIL no_timeout_wait ack=%0d stb_cycles=%0d exp -1 40", obs_ack, obs_cnt); end
    checks++; if (bus_err !== 1'b0 || wb_stb !== 1'b1) begin
      errors++; $display("FAIL no_timeout_state err=%b stb=%b exp 0 1", bus_err, wb_stb); end
    core_req = 1'b0;
    rst_core = 1'b1;
    #1;
    checks++; if (wb_stb !== 1'b0) begin
      errors++; $display("FAIL no_timeout_abort stb=%b exp 0", wb_stb); end
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_spurious_ack();
    test_reset_mid_bus();
    test_random();
`ifdef WB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kronos_wb_bridge.md
KRONOS_WB_BRIDGE -- requirements
Module: kronos_wb_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the number of bus-wait cycles before a forced termination (used only under WB_TIMEOUT_EN).
REQ-002 SHALL have parameter ERR_DATA, default 32'hFFFF_FFFF, meaning the read data returned on timeout.
REQ-003 SHALL have port clk_core, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_core, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports core_req (in, 1), core_addr (in, 32), core_wr_data (in, 32), core_mask (in, 4) and core_wr_en (in, 1): the Kronos-side request, held stable by the core until acknowledged.
REQ-006 SHALL have ports core_ack (out, 1) and core_rd_data (out, 32): the Kronos-side response.
REQ-007 SHALL have ports wb_cyc, wb_stb, wb_we (out, 1 each); wb_sel (out, 4); wb_addr and wb_dat_o (out, 32 each): the Wishbone classic master outputs.
REQ-008 SHALL have ports wb_dat_i (in, 32) and wb_ack (in, 1): the Wishbone slave response.
REQ-009 SHALL have port bus_err (out, 1): a timeout error flag.

Function
REQ-010 SHALL implement FSM states IDLE, BUS and RESP, with every output driven from registers.
REQ-011 In IDLE with core_req=1, SHALL latch addr, wr_data, mask and wr_en and go to BUS; wb_cyc and wb_stb SHALL rise on the next edge (request at cycle N gives stb at N+1).
REQ-012 In BUS, SHALL hold wb_cyc=wb_stb=1 and keep wb_addr, wb_we, wb_sel and wb_dat_o constant until wb_ack=1.
REQ-013 On the wb_ack=1 edge in BUS, SHALL capture wb_dat_i into core_rd_data, drop wb_cyc and wb_stb, and go to RESP.
REQ-014 In RESP, SHALL assert core_ack=1 for exactly one cycle and go to IDLE; core_req SHALL be ignored in RESP.
REQ-015 Minimum transfer time SHALL be 3 cycles from core_req to the next acceptance when wb_ack returns in the first BUS cycle.
REQ-016 For writes, SHALL drive wb_we=1, wb_sel=latched mask and wb_dat_o=latched wr_data.
REQ-017 For reads, SHALL drive wb_we=0, wb_sel=4'hF and wb_dat_o=0.
REQ-018 For writes, core_rd_data SHALL still load wb_dat_i (value don't-care to the core).
REQ-019 SHALL ignore wb_ack in IDLE and RESP, with no state or output change.
REQ-020 If core_req deasserts during BUS, the Wishbone cycle SHALL still complete and core_ack SHALL still pulse.
REQ-021 SHALL accept no new request while in BUS or RESP.

Reset
REQ-022 While rst_core=1, SHALL immediately force state=IDLE and all outputs to 0 (including core_rd_data=0 and bus_err=0), regardless of edge timing.
REQ-023 Reset asserted mid-BUS SHALL abandon the cycle with wb_cyc=0; no core_ack SHALL follow after release.
REQ-024 The first request SHALL be accepted on the first rising edge after rst_core deasserts with core_req=1.

Configuration
REQ-025 Macro WB_TIMEOUT_EN defined: a counter SHALL clear on BUS entry and increment each BUS cycle without wb_ack.
REQ-026 With WB_TIMEOUT_EN, when the counter reaches TIMEOUT_CYCLES-1 with wb_ack=0, SHALL drop wb_cyc and wb_stb, load core_rd_data=ERR_DATA, and go to RESP with bus_err=1 for that RESP cycle only.
REQ-027 With WB_TIMEOUT_EN, when wb_ack coincides with the terminal count, wb_ack SHALL win (normal completion, bus_err=0).
REQ-028 Macro WB_TIMEOUT_EN undefined: no counter SHALL exist, bus_err SHALL be tied 0, and BUS SHALL wait indefinitely.

Verification
REQ-029 Read: core_req=1, addr=32'h0000_0010, wr_en=0; slave acks after 2 cycles with 32'hCAFE_0001 -> stb at N+1, sel=4'hF, we=0, core_ack one cycle with core_rd_data=32'hCAFE_0001.
REQ-030 Write: addr=32'h0000_0104, data=32'h1234_5678, mask=4'b0011; ack in the first BUS cycle -> we=1, sel=4'b0011, dat_o=32'h1234_5678, core_ack at N+2, next request accepted at N+3.
REQ-031 Back-to-back: core_req held high across two reads -> exactly two stb pulses and two core_ack pulses, with IDLE between them.
REQ-032 Spurious wb_ack=1 in IDLE -> no core_ack, outputs unchanged.
REQ-033 Reset asserted in the 3rd BUS cycle -> wb_cyc=0 immediately, no core_ack after release, a subsequent read completes normally.
REQ-034 WB_TIMEOUT_EN with TIMEOUT_CYCLES=8 and no ack -> stb drops after 8 BUS cycles, core_ack and bus_err=1 together, core_rd_data=32'hFFFF_FFFF.
